// File: rtl/sequence_gen.sv
// -----------------------------------------------------------------------------
// sequence_gen
//
// Serial frame generator. This is the transmit-side partner of the 6-bit
// sequence_detect block.
//
// Words arrive on a valid/ready handshake and are buffered in a 2-entry FIFO.
// They are sent MSB-first on `data` as back-to-back 6-cycle frames. A frame
// boundary occurs every 6 cycles without stalling. If the FIFO is empty at a
// boundary, IDLE_WORD is sent instead, so the frame grid never slips.
//
// Handshake (in_valid / in_ready):
//   A word transfers on a rising edge where in_valid && in_ready.
//   While in_valid is high and in_ready is low, in_word must be held stable.
//   in_ready does not depend on in_valid, and it never rises in the same
//   cycle as a pop.
//
// Parameters
//   IDLE_WORD  fill word sent when the FIFO is empty at a frame boundary
//   CNT_W      width of the optional frame counters
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   in_valid     in_word is valid
//   in_word[5:0] parallel word; bit 5 goes out first
//   in_ready     FIFO can accept (combinational: rst_n && fifo not full)
//   data         registered serial output
//   frame_start  high while data carries bit 5 of a frame
//   frame_idle   high for all 6 cycles of an IDLE_WORD frame
//   word_cnt     words transmitted      (only with SEQ_GEN_CNT_EN)
//   idle_cnt     idle frames transmitted (only with SEQ_GEN_CNT_EN)
//   state_dbg    control state (0 = RESET, 1 = RUN)
//
// Optional feature
//   Define SEQ_GEN_CNT_EN to add the word_cnt/idle_cnt counters and ports.
// -----------------------------------------------------------------------------
module sequence_gen #(
  parameter logic [5:0] IDLE_WORD = 6'b000000,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [5:0]       in_word,
  output logic             in_ready,
  output logic             data,
  output logic             frame_start,
  output logic             frame_idle,
`ifdef SEQ_GEN_CNT_EN
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] idle_cnt,
`endif
  output logic             state_dbg
);

  typedef enum logic {
    ST_RESET = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e     state_q, state_d;

  logic [2:0] pos_q;
  logic [1:0] cnt_q;
  logic [5:0] mem0_q;   // FIFO head
  logic [5:0] mem1_q;   // FIFO second entry
  logic [4:0] shift_q;  // remaining bits of the current frame
  logic       data_q;
  logic       frame_start_q;
  logic       frame_idle_q;

  logic       load;
  logic       push;
  logic       pop;
  logic [5:0] src_word;

  // ---------------------------------------------------------------------------
  // Control FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM: next state. Reset itself is handled in the state register.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_RUN;
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_RESET;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM: outputs and strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_dbg = state_q;
    in_ready  = rst_n && (cnt_q != 2'd2);
    // Reset parks pos at 0, so the first edge out of reset is a load edge.
    load      = rst_n && (pos_q == 3'd0);
    push      = in_valid && in_ready;
    // A word pushed on a load edge into an empty FIFO is not seen here.
    // It waits for the next frame.
    pop       = load && (cnt_q != 2'd0);
    src_word  = pop ? mem0_q : IDLE_WORD;
  end

  // ---------------------------------------------------------------------------
  // Bit counter, FIFO and serializer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_q         <= 3'd0;
      cnt_q         <= 2'd0;
      mem0_q        <= 6'd0;
      mem1_q        <= 6'd0;
      shift_q       <= 5'd0;
      data_q        <= 1'b0;
      frame_start_q <= 1'b0;
      frame_idle_q  <= 1'b0;
    end else begin
      pos_q <= (pos_q == 3'd5) ? 3'd0 : pos_q + 3'd1;

      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            mem0_q <= in_word;
          end else begin
            mem1_q <= in_word;
          end
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          mem0_q <= mem1_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b11: begin
          // This case only happens at cnt_q == 1, because a full FIFO blocks
          // push. The old head leaves and the new word becomes the head.
          mem0_q <= in_word;
        end
        default: ;
      endcase

      if (load) begin
        data_q        <= src_word[5];
        shift_q       <= src_word[4:0];
        frame_start_q <= 1'b1;
        frame_idle_q  <= !pop;
      end else begin
        data_q        <= shift_q[4];
        shift_q       <= {shift_q[3:0], 1'b0};
        frame_start_q <= 1'b0;
      end
    end
  end

  assign data        = data_q;
  assign frame_start = frame_start_q;
  assign frame_idle  = frame_idle_q;

`ifdef SEQ_GEN_CNT_EN
  logic [CNT_W-1:0] word_cnt_q;
  logic [CNT_W-1:0] idle_cnt_q;

  // Both counters wrap naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_cnt_q <= '0;
      idle_cnt_q <= '0;
    end else if (load) begin
      if (pop) begin
        word_cnt_q <= word_cnt_q + 1'b1;
      end else begin
        idle_cnt_q <= idle_cnt_q + 1'b1;
      end
    end
  end

  assign word_cnt = word_cnt_q;
  assign idle_cnt = idle_cnt_q;
`endif

endmodule

// File: tb/tb_sequence_gen.sv
// -----------------------------------------------------------------------------
// tb_sequence_gen
//
// Testbench for sequence_gen.
//
// u_dut  uses the default IDLE_WORD.
// u_dut2 uses IDLE_WORD = 6'b011100, has no input traffic and shares the
//        same reset.
//
// The reference model tracks a frame position and a queue-based FIFO. It
// predicts every output bit. A word-level scoreboard (exp_q) reassembles
// each non-idle frame from `data` and compares it with the words in push
// order.
// -----------------------------------------------------------------------------
module tb_sequence_gen;

  localparam logic [5:0] IDLE1 = 6'b000000;
  localparam logic [5:0] IDLE2 = 6'b011100;

  // ---------------------------------------------------------------------------
  // Clock and DUT signals
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n    = 1'b0;
  logic       in_valid = 1'b0;
  logic [5:0] in_word  = 6'd0;
  logic       in_ready, data, frame_start, frame_idle, state_dbg;
  logic       in_ready2, data2, frame_start2, frame_idle2, state_dbg2;
`ifdef SEQ_GEN_CNT_EN
  logic [15:0] word_cnt, idle_cnt, word_cnt2, idle_cnt2;
`endif

  sequence_gen #(.IDLE_WORD(IDLE1), .CNT_W(16)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_word     (in_word),
    .in_ready    (in_ready),
    .data        (data),
    .frame_start (frame_start),
    .frame_idle  (frame_idle),
`ifdef SEQ_GEN_CNT_EN
    .word_cnt    (word_cnt),
    .idle_cnt    (idle_cnt),
`endif
    .state_dbg   (state_dbg)
  );

  sequence_gen #(.IDLE_WORD(IDLE2), .CNT_W(16)) u_dut2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (1'b0),
    .in_word     (6'd0),
    .in_ready    (in_ready2),
    .data        (data2),
    .frame_start (frame_start2),
    .frame_idle  (frame_idle2),
`ifdef SEQ_GEN_CNT_EN
    .word_cnt    (word_cnt2),
    .idle_cnt    (idle_cnt2),
`endif
    .state_dbg   (state_dbg2)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model and per-cycle compare
  // ---------------------------------------------------------------------------
  logic [5:0]  m_fifo[$];    // words accepted but not yet loaded
  logic [5:0]  exp_q[$];     // words accepted but not yet fully received
  bit          m_valid = 0;  // model has seen at least one edge
  bit          m_run   = 0;  // a frame is currently being sent
  int          m_pos   = 0;  // position of the next edge inside the frame
  int          m_idx   = 0;  // bit index (0 = MSB) now on data
  logic [5:0]  m_cur   = 6'd0;
  bit          m_cur_idle = 0;
  bit          e_data = 0, e_fs = 0, e_fi = 0;
  logic [15:0] m_wc = 0, m_ic = 0;

  // Reassembly of non-idle frames from the serial line.
  int          d_n = 6;
  bit          d_idle = 1;
  logic [5:0]  d_w = 6'd0;

  initial begin : model_and_compare
    bit push_ok;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_fifo.delete();
        exp_q.delete();
        m_pos = 0; m_idx = 0; m_run = 0;
        e_data = 0; e_fs = 0; e_fi = 0;
        m_wc = 0; m_ic = 0;
      end else begin
        push_ok = in_valid && (m_fifo.size() < 2);
        if (m_pos == 0) begin
          if (m_fifo.size() > 0) begin
            m_cur = m_fifo.pop_front(); m_cur_idle = 0; m_wc++;
          end else begin
            m_cur = IDLE1; m_cur_idle = 1; m_ic++;
          end
          m_run = 1;
        end
        m_idx  = m_pos;
        e_data = m_cur[5 - m_pos];
        e_fs   = (m_pos == 0);
        e_fi   = m_cur_idle;
        if (push_ok) begin
          m_fifo.push_back(in_word);
          exp_q.push_back(in_word);
        end
        m_pos = (m_pos + 1) % 6;
      end
      m_valid = 1;

      @(negedge clk);
      if (m_valid) begin
        check("data", data, e_data);
        check("frame_start", frame_start, e_fs);
        check("frame_idle", frame_idle, e_fi);
        check("in_ready", in_ready, rst_n && (m_fifo.size() < 2));
        check("data2", data2, m_run ? IDLE2[5 - m_idx] : 1'b0);
        check("frame_idle2", frame_idle2, m_run);
`ifdef SEQ_GEN_CNT_EN
        check("word_cnt", word_cnt, m_wc);
        check("idle_cnt", idle_cnt, m_ic);
`endif
        // Word-level scoreboard.
        if (!m_run) begin
          d_n = 6;
        end else begin
          if (frame_start) begin
            d_n = 0; d_w = 6'd0; d_idle = frame_idle;
          end
          if (d_n < 6) begin
            d_w = {d_w[4:0], data};
            d_n++;
            if (d_n == 6 && !d_idle) begin
              if (exp_q.size() == 0) check("sb_unexpected_word", {58'd0, d_w}, 64'hFFFF);
              else check("sb_word", d_w, exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Presents a word and holds it until it is accepted. in_valid stays high on
  // return so that back-to-back calls keep the line asserted.
  task automatic push_word(input logic [5:0] w);
    bit acc;
    in_valid = 1'b1;
    in_word  = w;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) return;
    end
    check("push_timeout", 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Waits at a negedge for a frame_start (optionally a non-idle one).
  // It gives up after 60 cycles.
  task automatic sync_frame(input bit need_word, output int waited);
    waited = 61;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (frame_start && (!need_word || !frame_idle)) begin
        waited = i;
        break;
      end
    end
    if (waited > 60) check("sync_timeout", 1'b0, 1'b1);
  endtask

  // Waits for the next non-idle frame, then collects nbits serial bits.
  task automatic grab(input int nbits, output logic [63:0] bits, output int waited);
    sync_frame(1'b1, waited);
    bits = {63'd0, data};
    for (int i = 1; i < nbits; i++) begin
      @(negedge clk);
      bits = {bits[62:0], data};
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed and random stimulus
  // ---------------------------------------------------------------------------
  initial begin : stimulus
    logic [63:0] bits;
    int          waited;
    int          fs_cnt;
    bit          any_one, all_idle, acc;
    int          dens;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data", data, 1'b0);
    check("rst_frame_start", frame_start, 1'b0);
    check("rst_frame_idle", frame_idle, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);

    // With no input, every frame is idle.
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk);
    fs_cnt = 0; any_one = 0; all_idle = 1;
    repeat (18) begin
      @(negedge clk);
      fs_cnt  += int'(frame_start);
      any_one |= data;
      all_idle &= frame_idle;
    end
    check("idle_fs_count", fs_cnt, 3);
    check("idle_data_zero", any_one, 1'b0);
    check("idle_flag_high", all_idle, 1'b1);
`ifdef SEQ_GEN_CNT_EN
    check("idle_cnt_18", idle_cnt, 16'd3);
`endif

    // A single word.
    push_word(6'b011100);
    in_valid = 1'b0;
    grab(6, bits, waited);
    check("single_word_bits", bits[5:0], 6'b011100);

    // Back-to-back words with the FIFO filling up.
    do_reset();
    fork
      begin
        sync_frame(1'b0, waited);
        @(posedge clk); #1;
        push_word(6'h1C);
        push_word(6'h2A);
        check("ready_low_after_2", in_ready, 1'b0);
        push_word(6'h15);
        push_word(6'h3F);
        in_valid = 1'b0;
      end
      begin
        grab(24, bits, waited);
      end
    join
    check("b2b_bits", bits[23:0], 24'h72A57F);
`ifdef SEQ_GEN_CNT_EN
    check("b2b_word_cnt", word_cnt, 16'd4);
`endif

    // A push on a load edge into an empty FIFO goes out one frame later.
    sync_frame(1'b0, waited);
    repeat (5) @(posedge clk);
    #1 in_valid = 1'b1; in_word = 6'b101101;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("loadpush_fs", frame_start, 1'b1);
    check("loadpush_idle_frame", frame_idle, 1'b1);
    grab(6, bits, waited);
    check("loadpush_latency", waited, 6);
    check("loadpush_bits", bits[5:0], 6'b101101);

    // Reset mid-frame with 2 words queued.
    sync_frame(1'b0, waited);
    in_valid = 1'b1; in_word = 6'b110011;
    @(posedge clk); #1 in_word = 6'b100001;
    @(posedge clk); #1 in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    check("midrst_ready_low", in_ready, 1'b0);
    @(negedge clk);
    check("midrst_data", data, 1'b0);
    check("midrst_fs", frame_start, 1'b0);
    check("midrst_fi", frame_idle, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("after_rst_fs", frame_start, 1'b1);
    check("after_rst_idle", frame_idle, 1'b1);
    check("after_rst_ready", in_ready, 1'b1);

    // The second instance sends its non-zero idle word in every frame.
    for (int i = 0; i < 12 && !frame_start2; i++) @(negedge clk);
    bits = 64'd0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      bits = {bits[62:0], data2};
    end
    check("idle2_bits", bits[5:0], 6'b011100);

    // Random traffic with varying density and occasional resets.
    dens = 30;
    for (int c = 0; c < 900; c++) begin
      if (c % 150 == 0) dens = (c / 150) % 3 == 0 ? 5 : ((c / 150) % 3 == 1 ? 40 : 95);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0; in_valid = 1'b0;
      end else begin
        rst_n = 1'b1;
        if (!in_valid || acc) begin
          in_valid = ($urandom_range(0, 99) < dens);
          in_word  = 6'($urandom_range(0, 63));
        end
      end
    end
    rst_n = 1'b1; in_valid = 1'b0;
    repeat (24) @(posedge clk);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
